// File: rtl/sub_recover_2_if.sv
// sub_recover_2_if: operand-in / result-out bundle for sub_recover_2.
//   slave  : the recovery block's view.
//   master : the driver/consumer view.
// Optional feature: SUB2_UFLOW_FLAG_EN adds the out_uflow result flag.
interface sub_recover_2_if #(
    parameter int DSIZE = 64,
    parameter int CNT_W = 16
);
    // Input side: sum word plus three of its addends.
    logic             in_valid;
    logic             in_ready;
    logic [DSIZE-1:0] in_s;
    logic [DSIZE-1:0] in_b;
    logic [DSIZE-1:0] in_c;
    logic [DSIZE-1:0] in_d;

    // Output side: recovered addend and the completed-result count.
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_diff;
    logic [CNT_W-1:0] out_count;
`ifdef SUB2_UFLOW_FLAG_EN
    logic             out_uflow;
`endif

    modport slave (
        input  in_valid,
        input  in_s,
        input  in_b,
        input  in_c,
        input  in_d,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_diff,
        output out_count
`ifdef SUB2_UFLOW_FLAG_EN
        ,
        output out_uflow
`endif
    );

    modport master (
        output in_valid,
        output in_s,
        output in_b,
        output in_c,
        output in_d,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_diff,
        input  out_count
`ifdef SUB2_UFLOW_FLAG_EN
        ,
        input  out_uflow
`endif
    );
endinterface

// File: rtl/sub_recover_2.sv
// sub_recover_2: recovers the fourth addend of a 4-operand sum,
//   out_diff = in_s - in_b - in_c - in_d (mod 2^DSIZE),
//   through a 2-stage valid/ready pipeline (1 result/cycle) and counts
//   completed output handshakes in a wrapping counter.
// Optional feature: define SUB2_UFLOW_FLAG_EN to add out_uflow, set when
//   the exact integer in_s - in_b - in_c - in_d is negative.
module sub_recover_2 #(
    parameter int DSIZE = 64,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    sub_recover_2_if.slave bus
);

`ifdef SUB2_UFLOW_FLAG_EN
    // Keep the exact integer so its sign can be flagged.
    localparam int S1_W   = DSIZE + 1;
    localparam int FULL_W = DSIZE + 3;
`else
    // Only the modular result is needed; carries above DSIZE are dropped.
    localparam int S1_W   = DSIZE;
    localparam int FULL_W = DSIZE;
`endif

    // Flow control
    logic v1;
    logic v2;
    logic adv1;
    logic adv2;
    logic in_ready_w;
    logic in_hs;
    logic out_hs;

    // Datapath
    logic [S1_W-1:0]   d_sb;
    logic [S1_W-1:0]   d_cd;
    logic [S1_W-1:0]   d_sb_next;
    logic [S1_W-1:0]   d_cd_next;
    logic [FULL_W-1:0] full_next;
    logic [DSIZE-1:0]  diff_q;
    logic [CNT_W-1:0]  count_q;
`ifdef SUB2_UFLOW_FLAG_EN
    logic              uflow_next;
    logic              uflow_q;
`endif

    // Advance rules: a stage moves when it is empty or the stage after it moves.
    // in_ready is combinational from out_ready; there is no skid buffer.
    // NOTE: always_comb assigns every output on every path, so no latch is inferred.
    always_comb begin
        adv2       = ~v2 | bus.out_ready;
        adv1       = ~v1 | adv2;
        in_ready_w = adv1 & ~rst;
        in_hs      = bus.in_valid & in_ready_w;
        out_hs     = v2 & bus.out_ready;
    end

`ifdef SUB2_UFLOW_FLAG_EN
    // Stage-1 operands widened by one bit so the partial results are exact.
    assign d_sb_next = {1'b0, bus.in_s} - {1'b0, bus.in_b};
    assign d_cd_next = {1'b0, bus.in_c} + {1'b0, bus.in_d};
    // d_sb is signed (sign-extend), d_cd unsigned (zero-extend).
    assign full_next  = {{2{d_sb[DSIZE]}}, d_sb} - {2'b00, d_cd};
    assign uflow_next = ($signed(full_next) < $signed({FULL_W{1'b0}}));
`else
    assign d_sb_next = bus.in_s - bus.in_b;
    assign d_cd_next = bus.in_c + bus.in_d;
    assign full_next = d_sb - d_cd;
`endif

    // Stage 1: load on input handshake; drop valid when advancing without one.
    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            d_sb <= '0;
            d_cd <= '0;
        end else if (adv1) begin
            v1 <= in_hs;
            if (in_hs) begin
                d_sb <= d_sb_next;
                d_cd <= d_cd_next;
            end
        end
    end

    // Stage 2: take stage 1 whenever the output side can move; hold under stall.
    // NOTE: datapath registers are reset too, because out_diff has a defined reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            diff_q  <= '0;
`ifdef SUB2_UFLOW_FLAG_EN
            uflow_q <= 1'b0;
`endif
        end else if (adv2) begin
            v2      <= v1;
            diff_q  <= full_next[DSIZE-1:0];
`ifdef SUB2_UFLOW_FLAG_EN
            uflow_q <= uflow_next;
`endif
        end
    end

    // Completed-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_hs) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = v2;
    assign bus.out_diff  = diff_q;
    assign bus.out_count = count_q;
`ifdef SUB2_UFLOW_FLAG_EN
    assign bus.out_uflow = uflow_q;
`endif

endmodule

// File: tb/tb_sub_recover_2.sv
// tb_sub_recover_2: directed self-checking bench for sub_recover_2
//   (DSIZE=8, CNT_W=4). Inputs change 1 time unit after the rising edge;
//   outputs are observed a further time unit later.
// Optional feature: SUB2_UFLOW_FLAG_EN enables the out_uflow checks.
module tb_sub_recover_2;
    localparam int DSIZE = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [CNT_W-1:0] exp_count = '0;

    sub_recover_2_if #(.DSIZE(DSIZE), .CNT_W(CNT_W)) bus ();

    sub_recover_2 #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DSIZE-1:0] s, input logic [DSIZE-1:0] b,
                         input logic [DSIZE-1:0] c, input logic [DSIZE-1:0] d);
        bus.in_valid = v;
        bus.in_s     = s;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_d     = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'd1, 8'd0, 8'd0, 8'd0);
        step();
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_low: got %b want 0", bus.in_ready); end
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_diff !== 8'd0) begin errors++; $display("FAIL rst_out_diff: got %0d want 0", bus.out_diff); end
        checks++; if (bus.out_count !== 4'd0) begin errors++; $display("FAIL rst_out_count: got %0d want 0", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_high: got %b want 1", bus.in_ready); end
`ifdef SUB2_UFLOW_FLAG_EN
        checks++; if (bus.out_uflow !== 1'b0) begin errors++; $display("FAIL rst_out_uflow: got %b want 0", bus.out_uflow); end
`endif
        exp_count = '0;
    endtask

    task automatic test_basic();
        // cycle 0: accept 100-10-20-30
        drive(1'b1, 8'd100, 8'd10, 8'd20, 8'd30);
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready); end
        step();
        // cycle 1: still in stage 1
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
        step();
        // cycle 2: result visible
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_diff !== 8'd40) begin errors++; $display("FAIL basic_diff: got %0d want 40", bus.out_diff); end
        checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL basic_count_pre: got %0d want %0d", bus.out_count, exp_count); end
`ifdef SUB2_UFLOW_FLAG_EN
        checks++; if (bus.out_uflow !== 1'b0) begin errors++; $display("FAIL basic_uflow: got %b want 0", bus.out_uflow); end
`endif
        step();
        exp_count++;
        // cycle 3: counted, pipeline empty
        #1;
        checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL basic_count_post: got %0d want %0d", bus.out_count, exp_count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_underflow();
        drive(1'b1, 8'd10, 8'd20, 8'd0, 8'd0);
        #1;
        step();
        drive(1'b1, 8'd0, 8'd255, 8'd255, 8'd255);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL uflow_early_valid: got %b want 0", bus.out_valid); end
        step();
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL uflow_valid0: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_diff !== 8'd246) begin errors++; $display("FAIL uflow_diff0: got %0d want 246", bus.out_diff); end
`ifdef SUB2_UFLOW_FLAG_EN
        checks++; if (bus.out_uflow !== 1'b1) begin errors++; $display("FAIL uflow_flag0: got %b want 1", bus.out_uflow); end
`endif
        step();
        exp_count++;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL uflow_valid1: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_diff !== 8'd3) begin errors++; $display("FAIL uflow_diff1: got %0d want 3", bus.out_diff); end
`ifdef SUB2_UFLOW_FLAG_EN
        checks++; if (bus.out_uflow !== 1'b1) begin errors++; $display("FAIL uflow_flag1: got %b want 1", bus.out_uflow); end
`endif
        step();
        exp_count++;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL uflow_drained: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL uflow_count: got %0d want %0d", bus.out_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        logic [DSIZE-1:0] vs [4];
        logic [DSIZE-1:0] vb [4];
        logic [DSIZE-1:0] vc [4];
        logic [DSIZE-1:0] vd [4];
        logic [DSIZE-1:0] ve [4];
        vs = '{8'd50, 8'd200, 8'd7, 8'd255};
        vb = '{8'd5,  8'd100, 8'd1, 8'd0};
        vc = '{8'd5,  8'd50,  8'd2, 8'd0};
        vd = '{8'd5,  8'd25,  8'd3, 8'd0};
        ve = '{8'd35, 8'd25,  8'd1, 8'd255};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b1, vs[i], vb[i], vc[i], vd[i]);
            else       drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            if (i >= 2) begin
                checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, bus.out_valid); end
                checks++; if (bus.out_diff !== ve[i-2]) begin errors++; $display("FAIL b2b_diff[%0d]: got %0d want %0d", i, bus.out_diff, ve[i-2]); end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid[%0d]: got %b want 0", i, bus.out_valid); end
            end
            step();
            if (i >= 2) exp_count++;
        end
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL b2b_count: got %0d want %0d", bus.out_count, exp_count); end
    endtask

    task automatic test_backpressure();
        // A = 90-10-10-10 = 60, B = 1-2-3-4 = -8 -> 248, C = 128-64-32-16 = 16
        bus.out_ready = 1'b0;
        drive(1'b1, 8'd90, 8'd10, 8'd10, 8'd10);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a: got %b want 1", bus.in_ready); end
        step();
        drive(1'b1, 8'd1, 8'd2, 8'd3, 8'd4);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_b: got %b want 1", bus.in_ready); end
        step();
        drive(1'b1, 8'd128, 8'd64, 8'd32, 8'd16);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready0: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_valid0: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_diff !== 8'd60) begin errors++; $display("FAIL bp_full_diff0: got %0d want 60", bus.out_diff); end
        step();
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready1: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_diff !== 8'd60) begin errors++; $display("FAIL bp_hold_diff: got %0d want 60", bus.out_diff); end
        // one-cycle release: A leaves, C enters
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b want 1", bus.out_valid); end
        step();
        exp_count++;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        checks++; if (bus.out_diff !== 8'd248) begin errors++; $display("FAIL bp_after_diff: got %0d want 248", bus.out_diff); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_after_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL bp_after_count: got %0d want %0d", bus.out_count, exp_count); end
        step();
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_diff !== 8'd248) begin errors++; $display("FAIL bp_drain_b: got %0d want 248", bus.out_diff); end
        step();
        exp_count++;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_c_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.out_diff !== 8'd16) begin errors++; $display("FAIL bp_drain_c: got %0d want 16", bus.out_diff); end
        step();
        exp_count++;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL bp_count: got %0d want %0d", bus.out_count, exp_count); end
    endtask

    task automatic test_count_wrap();
        rst = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        rst = 1'b0;
        exp_count = '0;
        bus.out_ready = 1'b1;
        // 17 bundles, s = j+3, b=c=d=1 -> result j
        for (int i = 0; i < 20; i++) begin
            if (i < 17) drive(1'b1, 8'(i + 3), 8'd1, 8'd1, 8'd1);
            else        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
            #1;
            checks++; if (bus.out_count !== exp_count) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, bus.out_count, exp_count); end
            if (i >= 2 && i <= 18) begin
                checks++; if (bus.out_diff !== 8'(i - 2)) begin errors++; $display("FAIL wrap_diff[%0d]: got %0d want %0d", i, bus.out_diff, i - 2); end
            end
            step();
            if (i >= 2 && i <= 18) exp_count++;
        end
        #1;
        checks++; if (bus.out_count !== 4'd1) begin errors++; $display("FAIL wrap_final: got %0d want 1", bus.out_count); end
    endtask

    task automatic test_reset_midflight();
        bus.out_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd0, 8'd0, 8'd0);
        #1;
        step();
        drive(1'b1, 8'd2, 8'd0, 8'd0, 8'd0);
        #1;
        step();
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", bus.in_ready); end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_count !== 4'd0) begin errors++; $display("FAIL mid_out_count: got %0d want 0", bus.out_count); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
        exp_count = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b want 0", i, bus.out_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_basic();
        test_underflow();
        test_back_to_back();
        test_backpressure();
        test_count_wrap();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
